// File: rtl/adc_pkg.sv
// Shared types and constants for the dual-slope ADC conversion sequencer.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUNUP   = 3'd2,
    ST_RUNDOWN = 3'd3,
    ST_DONE    = 3'd4
  } adc_state_e;

  localparam logic [1:0] CFG_RESET_LEN = 2'd0;
  localparam logic [1:0] CFG_RUNUP_LEN = 2'd1;
  localparam logic [1:0] CFG_TMO_LEN   = 2'd2;
  localparam logic [1:0] CFG_MODE      = 2'd3;

  localparam int RESET_LEN_DEF = 100000;
  localparam int RUNUP_LEN_DEF = 1000000;
  localparam int TMO_LEN_DEF   = 4000000;
  localparam int DEB_N_DEF     = 3;

endpackage

// File: rtl/adc_cmp_filter.sv
// Comparator conditioning: two-flop synchroniser followed by a run-length debounce.
// The filtered level flips only after DEB_N consecutive disagreeing samples.
module adc_cmp_filter #(
  parameter int DEB_N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cmp,
  output logic level,
  output logic rise
);

  localparam int DW = (DEB_N < 2) ? 1 : $clog2(DEB_N);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      run_cnt <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1 <= cmp;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == DW'(DEB_N - 1)) begin
        // DEB_N-th disagreeing sample in a row: accept the new level
        level   <= sync2;
        rise    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Dual-slope integrator sequencer: reset -> runup -> rundown, result via valid/ready.
// Optional continuous conversion loop enabled by defining ADC_CONT_EN.
//
// state   | meaning
// IDLE    | integrator shorted, waiting for start
// RESET   | integrator shorted for reset_len cycles
// RUNUP   | integrating the input for runup_len cycles
// RUNDOWN | integrating the reference until comparator rise or timeout
// DONE    | result presented, waiting for res_ready
module adc_conv_ctrl
  import adc_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int RESET_DEF = RESET_LEN_DEF,
  parameter int RUNUP_DEF = RUNUP_LEN_DEF,
  parameter int TMO_DEF   = TMO_LEN_DEF,
  parameter int DEB_N     = DEB_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_tmo,
  output logic             m_reset,
  output logic             m_in,
  input  logic             cmp,
  output logic [2:0]       state_o
);

  function automatic logic [CNT_W-1:0] non_zero(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  adc_state_e       state;
  logic [CNT_W-1:0] ph_cnt;
  logic [CNT_W-1:0] reset_sh, runup_sh, tmo_sh;
  logic [CNT_W-1:0] reset_len, runup_len, tmo_len;
  logic             cmp_level;
  logic             cmp_rise;
  logic             cmp_hit;

`ifdef ADC_CONT_EN
  logic cont_mode;
`endif

  adc_cmp_filter #(.DEB_N(DEB_N)) u_cmp_filter (
    .clk   (clk),
    .rst   (rst),
    .cmp   (cmp),
    .level (cmp_level),
    .rise  (cmp_rise)
  );

  assign cmp_hit = cmp_rise && cmp_level;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      reset_sh <= CNT_W'(RESET_DEF);
      runup_sh <= CNT_W'(RUNUP_DEF);
      tmo_sh   <= CNT_W'(TMO_DEF);
`ifdef ADC_CONT_EN
      cont_mode <= 1'b0;
`endif
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_RESET_LEN: reset_sh <= cfg_wdata;
        CFG_RUNUP_LEN: runup_sh <= cfg_wdata;
        CFG_TMO_LEN:   tmo_sh   <= cfg_wdata;
`ifdef ADC_CONT_EN
        CFG_MODE:      cont_mode <= cfg_wdata[0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ph_cnt    <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_tmo   <= 1'b0;
      m_reset   <= 1'b0;
      m_in      <= 1'b0;
      reset_len <= non_zero(CNT_W'(RESET_DEF));
      runup_len <= non_zero(CNT_W'(RUNUP_DEF));
      tmo_len   <= non_zero(CNT_W'(TMO_DEF));
    end else begin
      unique case (state)
        ST_IDLE: begin
          ph_cnt <= '0;
          if (start) begin
            reset_len <= non_zero(reset_sh);
            runup_len <= non_zero(runup_sh);
            tmo_len   <= non_zero(tmo_sh);
            state     <= ST_RESET;
            busy      <= 1'b1;
          end
        end

        ST_RESET: begin
          if (ph_cnt == reset_len - CNT_W'(1)) begin
            state   <= ST_RUNUP;
            ph_cnt  <= '0;
            m_reset <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + CNT_W'(1);
          end
        end

        ST_RUNUP: begin
          if (ph_cnt == runup_len - CNT_W'(1)) begin
            state  <= ST_RUNDOWN;
            ph_cnt <= '0;
            m_in   <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + CNT_W'(1);
          end
        end

        ST_RUNDOWN: begin
          // The comparator edge takes priority over a coincident timeout
          if (cmp_hit || ph_cnt == tmo_len - CNT_W'(1)) begin
            res_count <= cmp_hit ? ph_cnt : tmo_len;
            res_tmo   <= !cmp_hit;
            res_valid <= 1'b1;
            state     <= ST_DONE;
            ph_cnt    <= '0;
            m_reset   <= 1'b0;
            m_in      <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          ph_cnt <= '0;
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef ADC_CONT_EN
            if (cont_mode) begin
              reset_len <= non_zero(reset_sh);
              runup_len <= non_zero(runup_sh);
              tmo_len   <= non_zero(tmo_sh);
              state     <= ST_RESET;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= ST_IDLE;
          ph_cnt    <= '0;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          m_reset   <= 1'b0;
          m_in      <= 1'b0;
        end
      endcase
    end
  end

endmodule
